// File: rtl/voice_mixer_scheduler.sv
// Shares one sample-memory read port among NUM_VOICES sampler voices. On each sample tick it
// reads one sample per active voice in order 0..N-1, sums them, and publishes the mix.
module voice_mixer_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MIX_W      = DATA_W + $clog2(NUM_VOICES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick_i,
    input  logic [NUM_VOICES-1:0]        trigger_i,
    input  logic [NUM_VOICES*ADDR_W-1:0] start_addr_i,
    input  logic [NUM_VOICES*ADDR_W-1:0] end_addr_i,
    input  logic [NUM_VOICES-1:0]        loop_en_i,
    output logic                         mem_req_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic [DATA_W-1:0]            mem_data_i,
    output logic [NUM_VOICES-1:0]        active_o,
    output logic [MIX_W-1:0]             mix_out_o,
    output logic                         mix_valid_o,
    output logic                         overrun_o
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {StIdle, StScan, StReq, StOut} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [MIX_W-1:0]        acc_q, acc_d;
    logic [ADDR_W-1:0]       ptr_q [NUM_VOICES];
    logic [ADDR_W-1:0]       ptr_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   active_q, active_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [MIX_W-1:0]        mix_out_q, mix_out_d;
    logic                    mix_valid_q, mix_valid_d;
    logic                    overrun_q, overrun_d;

    logic [ADDR_W-1:0]       cur_start, cur_end;
    logic [MIX_W-1:0]        acc_sum;
    logic                    last_voice;

    assign cur_start  = start_addr_i[int'(idx_q)*ADDR_W +: ADDR_W];
    assign cur_end    = end_addr_i[int'(idx_q)*ADDR_W +: ADDR_W];
    assign acc_sum    = acc_q + {{(MIX_W-DATA_W){mem_data_i[DATA_W-1]}}, mem_data_i};
    assign last_voice = (idx_q == IDX_W'(NUM_VOICES - 1));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        ptr_d       = ptr_q;
        active_d    = active_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = sample_tick_i && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (sample_tick_i) begin
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (active_q[idx_q]) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = ptr_q[idx_q];
                    state_d    = StReq;
                end else if (last_voice) begin
                    // Mix is registered on entry to StOut so mix_valid lines up with that cycle.
                    mix_out_d   = acc_q;
                    mix_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StReq: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    acc_d     = acc_sum;
                    if (ptr_q[idx_q] == cur_end) begin
                        if (loop_en_i[idx_q]) begin
                            ptr_d[idx_q] = cur_start;
                        end else begin
                            active_d[idx_q] = 1'b0;
                        end
                    end else begin
                        ptr_d[idx_q] = ptr_q[idx_q] + ADDR_W'(1);
                    end
                    if (last_voice) begin
                        mix_out_d   = acc_sum;
                        mix_valid_d = 1'b1;
                        state_d     = StOut;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StScan;
                    end
                end
            end
            StOut: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Triggers win over any same-cycle advance or stop.
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (trigger_i[i]) begin
                ptr_d[i]    = start_addr_i[i*ADDR_W +: ADDR_W];
                active_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            ptr_q       <= '{default: '0};
            active_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            ptr_q       <= ptr_d;
            active_q    <= active_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign active_o    = active_q;
    assign mix_out_o   = mix_out_q;
    assign mix_valid_o = mix_valid_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_voice_mixer_scheduler.sv
// Bench for voice_mixer_scheduler: a pass-level timeline model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_voice_mixer_scheduler;
    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 8;
    localparam int MW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            sample_tick;
    logic [N-1:0]    trigger;
    logic [N*AW-1:0] start_addr, end_addr;
    logic [N-1:0]    loop_en;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack;
    logic [DW-1:0]   mem_data;
    logic [N-1:0]    active;
    logic [MW-1:0]   mix_out;
    logic            mix_valid, overrun;

    always #5 clk = ~clk;

    voice_mixer_scheduler #(.NUM_VOICES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick_i(sample_tick),
        .trigger_i    (trigger),
        .start_addr_i (start_addr),
        .end_addr_i   (end_addr),
        .loop_en_i    (loop_en),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_data),
        .active_o     (active),
        .mix_out_o    (mix_out),
        .mix_valid_o  (mix_valid),
        .overrun_o    (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem_tbl [0:4095];

    // Model: voice state plus a per-pass timeline built when a tick is accepted.
    logic [AW-1:0] m_ptr [N];
    logic [N-1:0]  m_act = '0;
    logic [MW-1:0] m_mix = '0;
    bit            pass_on = 0;
    int            t0 = 0, out_off = 0;
    logic [MW-1:0] plan_mix;
    bit            plan_req [32];
    logic [AW-1:0] plan_addr [32];
    bit            plan_ack [32];
    int            plan_v [32];
    int            k_fixed = 1;
    bit            e_req = 0, e_mv = 0, e_ov = 0, e_busy = 0;
    logic [AW-1:0] e_addr = '0;

    logic [MW-1:0] q_mix [$];
    int            q_mvc [$];
    logic [AW-1:0] q_addr [$];
    int            n_ov = 0;
    bit            prev_req = 0;
    int            mo;
    bit            busy_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] start_of(input int v);
        return start_addr[v*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] end_of(input int v);
        return end_addr[v*AW +: AW];
    endfunction

    task automatic plan_pass(input int t);
        int off, k;
        logic [MW-1:0] sum;
        logic [DW-1:0] d;
        t0 = t;
        pass_on = 1;
        sum = '0;
        for (int j = 0; j < 32; j++) begin
            plan_req[j] = 0; plan_ack[j] = 0; plan_v[j] = 0; plan_addr[j] = '0;
        end
        off = 1;
        for (int v = 0; v < N; v++) begin
            if (!m_act[v]) begin
                off++;
            end else begin
                k = (k_fixed > 0) ? k_fixed : int'($urandom_range(4, 1));
                for (int j = 1; j <= k; j++) begin
                    plan_req[off+j] = 1;
                    plan_addr[off+j] = m_ptr[v];
                end
                plan_ack[off+k] = 1;
                plan_v[off+k] = v;
                d = mem_tbl[m_ptr[v][11:0]];
                sum = sum + {{(MW-DW){d[DW-1]}}, d};
                off += 1 + k;
            end
        end
        out_off = off;
        plan_mix = sum;
    endtask

    always @(negedge clk) begin
        chk("mem_req", 32'(mem_req), 32'(e_req));
        if (e_req) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("active", 32'(active), 32'(m_act));
        chk("mix_valid", 32'(mix_valid), 32'(e_mv));
        chk("mix_out", 32'(mix_out), 32'(m_mix));
        chk("overrun", 32'(overrun), 32'(e_ov));
        if (mix_valid) begin
            q_mix.push_back(mix_out);
            q_mvc.push_back(cyc);
        end
        if (mem_req && !prev_req) q_addr.push_back(mem_addr);
        if (overrun) n_ov++;
        prev_req = mem_req;

        if (reset) begin
            pass_on = 0;
            m_act = '0;
            for (int i = 0; i < N; i++) m_ptr[i] = '0;
            m_mix = '0;
            e_req = 0; e_mv = 0; e_ov = 0; e_busy = 0;
        end else begin
            mo = cyc - t0;
            busy_now = pass_on && mo >= 1 && mo <= out_off;
            if (busy_now) begin
                if (plan_ack[mo]) begin
                    if (m_ptr[plan_v[mo]] == end_of(plan_v[mo])) begin
                        if (loop_en[plan_v[mo]]) m_ptr[plan_v[mo]] = start_of(plan_v[mo]);
                        else m_act[plan_v[mo]] = 1'b0;
                    end else begin
                        m_ptr[plan_v[mo]] = m_ptr[plan_v[mo]] + 1'b1;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (trigger[i]) begin
                    m_ptr[i] = start_of(i);
                    m_act[i] = 1'b1;
                end
            end
            e_ov = sample_tick && busy_now;
            if (sample_tick && !busy_now) plan_pass(cyc);
            mo = cyc + 1 - t0;
            e_busy = pass_on && mo >= 1 && mo <= out_off;
            e_req = 0;
            e_mv = 0;
            if (e_busy) begin
                e_req = plan_req[mo];
                e_addr = plan_addr[mo];
                e_mv = (mo == out_off);
                if (e_mv) m_mix = plan_mix;
            end
        end
    end

    // Memory responder: acks exactly when the timeline says, data from the table.
    initial begin
        int off;
        mem_ack = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            off = cyc - t0;
            mem_ack = 1'b0;
            if (!reset && pass_on && off >= 1 && off <= out_off) mem_ack = plan_ack[off];
            mem_data = mem_tbl[mem_addr[11:0]];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tick_cyc;
    int q_tick [$];
    int ov_base;

    task automatic step();
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        trigger = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic tick_now();
        step();
        sample_tick = 1'b1;
        tick_cyc = cyc;
        q_tick.push_back(cyc);
    endtask

    task automatic cfg(input int v, input int s, input int e, input bit l);
        start_addr[v*AW +: AW] = AW'(s);
        end_addr[v*AW +: AW] = AW'(e);
        loop_en[v] = l;
    endtask

    task automatic clear_q();
        q_mix.delete();
        q_mvc.delete();
        q_addr.delete();
        q_tick.delete();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_tbl[i] = DW'($urandom);
        reset = 1'b1;
        sample_tick = 1'b0;
        trigger = '0;
        start_addr = '0;
        end_addr = '0;
        loop_en = '0;
        idle(3);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_mix_out", 32'(mix_out), 0);
        chk("rst_mix_valid", 32'(mix_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        idle(2);

        // No voices active.
        clear_q();
        tick_now();
        idle(12);
        chk("idle_no_req", 32'(q_addr.size()), 0);
        chk("idle_mv_count", 32'(q_mix.size()), 1);
        chk("idle_mix", 32'(q_mix[0]), 0);
        chk("idle_mv_cycle", 32'(q_mvc[0] - q_tick[0]), 5);

        // Voice 0, one-shot over three samples.
        mem_tbl['h100] = 8'd10;
        mem_tbl['h101] = 8'd20;
        mem_tbl['h102] = 8'd30;
        cfg(0, 'h100, 'h102, 1'b0);
        step();
        trigger = 4'b0001;
        idle(2);
        clear_q();
        repeat (4) begin
            tick_now();
            idle(12);
        end
        chk("stop_addr_count", 32'(q_addr.size()), 3);
        chk("stop_addr0", 32'(q_addr[0]), 32'h100);
        chk("stop_addr1", 32'(q_addr[1]), 32'h101);
        chk("stop_addr2", 32'(q_addr[2]), 32'h102);
        chk("stop_mix0", 32'(q_mix[0]), 10);
        chk("stop_mix1", 32'(q_mix[1]), 20);
        chk("stop_mix2", 32'(q_mix[2]), 30);
        chk("stop_mix3", 32'(q_mix[3]), 0);
        chk("stop_mv_cycle", 32'(q_mvc[0] - q_tick[0]), 6);
        chk("stop_active0", 32'(active[0]), 0);

        // Same voice, looping.
        cfg(0, 'h100, 'h102, 1'b1);
        step();
        trigger = 4'b0001;
        idle(2);
        clear_q();
        repeat (4) begin
            tick_now();
            idle(12);
        end
        chk("loop_addr3", 32'(q_addr[3]), 32'h100);
        chk("loop_mix3", 32'(q_mix[3]), 10);
        chk("loop_active0", 32'(active[0]), 1);

        // All four voices, extreme samples.
        for (int v = 0; v < N; v++) begin
            cfg(v, 'h200 + 16 * v, 'h200 + 16 * v, 1'b1);
            mem_tbl['h200 + 16 * v] = 8'h80;
        end
        step();
        trigger = 4'b1111;
        idle(2);
        clear_q();
        tick_now();
        idle(14);
        chk("all_neg_mix", 32'(q_mix[0]), 32'h200);
        chk("all_mv_cycle", 32'(q_mvc[0] - q_tick[0]), 9);
        for (int v = 0; v < N; v++) mem_tbl['h200 + 16 * v] = 8'd127;
        clear_q();
        tick_now();
        idle(14);
        chk("all_pos_mix", 32'(q_mix[0]), 508);

        // Ack delayed: ack on the fourth REQ cycle.
        k_fixed = 4;
        clear_q();
        tick_now();
        idle(30);
        chk("slow_mix", 32'(q_mix[0]), 508);
        chk("slow_mv_cycle", 32'(q_mvc[0] - q_tick[0]), 21);

        // Tick during REQ of voice 0.
        clear_q();
        ov_base = n_ov;
        tick_now();
        idle(2);
        step();
        sample_tick = 1'b1;
        idle(30);
        chk("ovr_pulses", 32'(n_ov - ov_base), 1);
        chk("ovr_mv_count", 32'(q_mix.size()), 1);

        // Reset while a request is outstanding.
        tick_now();
        idle(3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_mem_req", 32'(mem_req), 0);
        chk("midrst_active", 32'(active), 0);
        idle(3);

        // Retrigger voice 1 on the cycle of its final ack.
        k_fixed = 1;
        cfg(1, 'h300, 'h300, 1'b0);
        mem_tbl['h300] = 8'd5;
        step();
        trigger = 4'b0010;
        idle(2);
        clear_q();
        tick_now();
        idle(2);
        step();
        trigger = 4'b0010;
        idle(12);
        chk("retrig_active1", 32'(active[1]), 1);
        chk("retrig_mix", 32'(q_mix[0]), 5);
        tick_now();
        idle(12);
        chk("retrig_addr", 32'(q_addr[1]), 32'h300);

        // Randomised traffic.
        k_fixed = 0;
        for (int ph = 0; ph < 3; ph++) begin
            idle(30);
            for (int v = 0; v < N; v++) begin
                int s;
                s = int'($urandom_range(32'hF00, 0));
                cfg(v, s, s + int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
            end
            for (int c = 0; c < 600; c++) begin
                step();
                if (!e_busy && $urandom_range(5, 0) == 0) trigger = N'($urandom);
                if ($urandom_range(9, 0) == 0) sample_tick = 1'b1;
            end
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/voice_mixer_scheduler.md
# voice_mixer_scheduler

Sequences per-sample playback of `NUM_VOICES` sampler voices that share one sample-memory read port. On each 44.1 kHz `sample_tick` strobe from the sample-rate divider, it walks the voices in fixed order 0..N-1 and issues one memory read per active voice through a req/ack handshake. It sums the returned signed samples, advances each voice's playback pointer with loop or stop at end, and presents one mixed sample per tick to the audio output stage.

## Interface
Parameters:
- `NUM_VOICES`, 4: number of voices; ≥2, power of two.
- `ADDR_W`, 20: sample-memory address width.
- `DATA_W`, 8: signed sample width.
- `MIX_W`, derived: `DATA_W + $clog2(NUM_VOICES)`; mix width, never overflows.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `sample_tick`  in  1  one-cycle strobe, one per sample period.
- `trigger`  in  NUM_VOICES  one-cycle start strobes, bit i = voice i.
- `start_addr`  in  NUM_VOICES*ADDR_W  per-voice first address; voice i at bits [i*ADDR_W +: ADDR_W].
- `end_addr`  in  NUM_VOICES*ADDR_W  per-voice last address, inclusive; same packing.
- `loop_en`  in  NUM_VOICES  per voice: 1 = wrap to start at end, 0 = stop.
- `mem_req`  out  1  read request.
- `mem_addr`  out  ADDR_W  read address; stable while `mem_req`=1.
- `mem_ack`  in  1  read complete; `mem_data` is valid in the same cycle.
- `mem_data`  in  DATA_W  signed sample.
- `active`  out  NUM_VOICES  voice playing flags.
- `mix_out`  out  MIX_W  signed mixed sample; holds its value between updates.
- `mix_valid`  out  1  one-cycle pulse when `mix_out` is updated.
- `overrun`  out  1  one-cycle pulse when a tick is dropped.

## Operation
- States:
  - IDLE: waits for `sample_tick`.
  - SCAN: examines voice `idx`.
  - REQ: waits for `mem_ack`.
  - OUT: publishes the mix.
- IDLE + `sample_tick`: `idx`←0, `acc`←0, go to SCAN.
- SCAN, `active[idx]`=0: if `idx`=N-1 go to OUT, else `idx`+1 and stay in SCAN. Costs 1 cycle.
- SCAN, `active[idx]`=1: `mem_req`←1, `mem_addr`←`ptr[idx]`, go to REQ.
- REQ, `mem_ack`=0: hold `mem_req` and `mem_addr`. No timeout.
- REQ, `mem_ack`=1:
  - `mem_req`←0.
  - `acc` += sign-extended `mem_data`.
  - Pointer update: if `ptr`=`end_addr[idx]`, then `ptr`←`start_addr[idx]` when `loop_en[idx]`=1, otherwise `active[idx]`←0. Else `ptr`+1.
  - Next: if `idx`=N-1 go to OUT, else `idx`+1 and go to SCAN.
- OUT: `mix_out`←`acc`, `mix_valid`=1 for this cycle only, then IDLE.
- `trigger[i]`, accepted in any state: `ptr[i]`←`start_addr[i]`, `active[i]`←1.
  - Overrides any pointer advance or stop for voice i in the same cycle.
  - A sample already accepted by `mem_ack` in that cycle is still accumulated.
- `sample_tick` in any state other than IDLE: the tick is dropped and `overrun` pulses for 1 cycle. The current pass is unaffected.
- `start_addr` > `end_addr` is illegal; behaviour is undefined and not checked.
- Arithmetic:
  - Two's-complement signed throughout.
  - `acc` is MIX_W bits wide, so it cannot overflow.
  - Address increments are ADDR_W-bit modulo.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=0.
  - `active`=0, `mix_out`=0.
  - `mix_valid`=0, `overrun`=0.
  - State IDLE, all `ptr`=0.
- Reset mid-transaction drops `mem_req` on the next edge. The memory side must tolerate an abandoned request.
- Every output is registered.
- `mem_req` rises 1 cycle after entering SCAN for an active voice. It falls on the edge after the `mem_ack` cycle.
- Tick seen in cycle 0: SCAN is in cycle 1.
- Per-voice cost: inactive = 1 cycle; active = 1 + k cycles, where k ≥ 1 is the number of REQ cycles up to and including the ack.
- `mix_valid` cycle = 1 + Σ(per-voice cost).
  - All 4 voices active with immediate ack: cycle 9.
  - All voices idle: cycle 5.
- A pass must finish within one sample period (2268 cycles at 100 MHz). Otherwise `overrun` fires.

## Test plan
- Reset, then a tick with no voices active → `mem_req` never asserts; `mix_valid`=1 at cycle 5 with `mix_out`=0.
- Trigger voice 0, start=0x100, end=0x102, `loop_en`=0; memory returns 10, 20, 30 with immediate ack → across ticks the addresses are 0x100, 0x101, 0x102; mixes are 10, 20, 30; `active[0]` clears after the third tick; the fourth tick gives mix 0 with no request.
- Same setup with `loop_en`=1 → the address sequence is 0x100, 0x101, 0x102, 0x100; `active[0]` stays 1.
- All 4 voices active, returning -128, -128, -128, -128 → `mix_out`=-512 (10'h200). With returns 127 each → 508. `mix_valid` at cycle 9.
- Memory ack delayed 3 cycles → `mem_req` and `mem_addr` are held stable through the wait; the mix result is unchanged.
- Tick issued again during REQ → `overrun` pulses once and there is no second `mix_valid` for it. Separately, `trigger[1]` in the same cycle as voice 1's ack at its end address with `loop_en`=0 → `active[1]` stays 1 and `ptr[1]`=`start_addr[1]`.
